hand_cmd_parser: RTL and testbench

Byte-stream parser that sits directly downstream of the UART receiver on the hand interface. It takes `i_Rx_DV`/`i_Rx_Byte` from the receiver and decodes ASCII finger commands of the form `F<n> <decimal>\n`. It keeps one position register per finger, pulses an update strobe on each accepted frame, and counts malformed frames. The Avalon/register layer reads its outputs.

---
 rtl/hand_cmd_parser.sv | 165 ++++++++++++++++
 tb/tb_hand_cmd_parser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hand_cmd_parser.sv
// Parses "F<n> <decimal>\n" frames from the UART byte stream into per-finger position registers.
// Commit/error pulses appear one cycle after the deciding byte; one byte per cycle, never backpressures.
module hand_cmd_parser #(
  parameter int NUM_FINGERS = 5,
  parameter int POS_WIDTH   = 16,
  parameter int MAX_DIGITS  = 5
) (
  input  logic                             i_Clock,
  input  logic                             i_Reset,
  input  logic                             i_Rx_DV,
  input  logic [7:0]                       i_Rx_Byte,
  output logic [NUM_FINGERS*POS_WIDTH-1:0] o_Position,
  output logic                             o_Pos_Valid,
  output logic [3:0]                       o_Pos_Finger,
  output logic [POS_WIDTH-1:0]             o_Pos_Value,
  output logic                             o_Frame_Error,
  output logic [15:0]                      o_Error_Count
);

  localparam int AW = POS_WIDTH + 4;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [7:0] MAX_FCHAR = 8'(48 + NUM_FINGERS);

  typedef enum logic [2:0] {S_IDLE, S_FINGER, S_SPACE, S_DIGITS, S_SKIP} state_t;

  state_t                           state_q, state_d;
  logic [3:0]                       finger_q, finger_d;
  logic [AW-1:0]                    acc_q, acc_d, acc_nxt;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             ovf_q, ovf_d;
  logic [NUM_FINGERS*POS_WIDTH-1:0] pos_q, pos_d;
  logic                             pos_vld_q, pos_vld_d;
  logic [3:0]                       pos_finger_q, pos_finger_d;
  logic [POS_WIDTH-1:0]             pos_value_q, pos_value_d;
  logic                             frame_err_q, frame_err_d;
  logic [15:0]                      err_cnt_q, err_cnt_d;
  logic                             err, commit;
  logic                             is_lf, is_digit, is_fdigit;

  assign is_lf     = (i_Rx_Byte == 8'h0A);
  assign is_digit  = (i_Rx_Byte >= 8'h30) && (i_Rx_Byte <= 8'h39);
  assign is_fdigit = (i_Rx_Byte >= 8'h31) && (i_Rx_Byte <= MAX_FCHAR);
  // acc*10 + digit; low nibble of an ASCII digit is its value
  assign acc_nxt   = (acc_q << 3) + (acc_q << 1) + {{(AW-4){1'b0}}, i_Rx_Byte[3:0]};

  always_comb begin
    state_d      = state_q;
    finger_d     = finger_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    pos_d        = pos_q;
    pos_vld_d    = 1'b0;
    pos_finger_d = pos_finger_q;
    pos_value_d  = pos_value_q;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;
    err          = 1'b0;
    commit       = 1'b0;

    if (i_Rx_DV && (i_Rx_Byte != 8'h0D)) begin
      case (state_q)
        S_IDLE: begin
          if (i_Rx_Byte == 8'h46) state_d = S_FINGER;
          else if (!is_lf) begin
            err     = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_FINGER: begin
          if (is_fdigit) begin
            finger_d = i_Rx_Byte[3:0];
            state_d  = S_SPACE;
          end else begin
            err     = 1'b1;
            state_d = is_lf ? S_IDLE : S_SKIP;
          end
        end
        S_SPACE: begin
          if (i_Rx_Byte == 8'h20) begin
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = S_DIGITS;
          end else begin
            err     = 1'b1;
            state_d = is_lf ? S_IDLE : S_SKIP;
          end
        end
        S_DIGITS: begin
          if (is_digit) begin
            if (cnt_q < CW'(MAX_DIGITS)) begin
              acc_d = acc_nxt;
              cnt_d = cnt_q + 1'b1;
              if (|acc_nxt[AW-1:POS_WIDTH]) ovf_d = 1'b1;
            end else begin
              err     = 1'b1;
              state_d = S_SKIP;
            end
          end else if (is_lf) begin
            if ((cnt_q != '0) && !ovf_q) commit = 1'b1;
            else                         err    = 1'b1;
            state_d = S_IDLE;
          end else begin
            err     = 1'b1;
            state_d = S_SKIP;
          end
        end
        S_SKIP: begin
          if (is_lf) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (err) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end
    if (commit) begin
      pos_vld_d    = 1'b1;
      pos_finger_d = finger_q;
      pos_value_d  = acc_q[POS_WIDTH-1:0];
    end
    for (int k = 0; k < NUM_FINGERS; k++) begin
      if (commit && (finger_q == 4'(k + 1))) pos_d[k*POS_WIDTH +: POS_WIDTH] = acc_q[POS_WIDTH-1:0];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= S_IDLE;
      finger_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      pos_q        <= '0;
      pos_vld_q    <= 1'b0;
      pos_finger_q <= '0;
      pos_value_q  <= '0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      finger_q     <= finger_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      pos_q        <= pos_d;
      pos_vld_q    <= pos_vld_d;
      pos_finger_q <= pos_finger_d;
      pos_value_q  <= pos_value_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign o_Position    = pos_q;
  assign o_Pos_Valid   = pos_vld_q;
  assign o_Pos_Finger  = pos_finger_q;
  assign o_Pos_Value   = pos_value_q;
  assign o_Frame_Error = frame_err_q;
  assign o_Error_Count = err_cnt_q;

endmodule

// File: tb/tb_hand_cmd_parser.sv
// Bench for hand_cmd_parser: line-level reference model checked every cycle, plus literal spot checks.
module tb_hand_cmd_parser;
  localparam int NF = 5;
  localparam int PW = 16;
  localparam int MD = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              dv;
  logic [7:0]        rx;
  logic [NF*PW-1:0]  o_position;
  logic              o_pos_valid;
  logic [3:0]        o_pos_finger;
  logic [PW-1:0]     o_pos_value;
  logic              o_frame_error;
  logic [15:0]       o_error_count;

  hand_cmd_parser #(.NUM_FINGERS(NF), .POS_WIDTH(PW), .MAX_DIGITS(MD)) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Rx_DV      (dv),
    .i_Rx_Byte    (rx),
    .o_Position   (o_position),
    .o_Pos_Valid  (o_pos_valid),
    .o_Pos_Finger (o_pos_finger),
    .o_Pos_Value  (o_pos_value),
    .o_Frame_Error(o_frame_error),
    .o_Error_Count(o_error_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_vld  = 0;
  int n_err  = 0;
  int v0, e0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: judges each line prefix as a string ----------------
  logic [7:0]  line[$];
  logic [15:0] m_pos[NF];
  logic [3:0]  m_finger;
  logic [15:0] m_value;
  logic [15:0] m_cnt;
  logic        m_vld, m_err;

  function automatic bit ok_at(input logic [7:0] b, input int i);
    if (i == 0) return b == 8'h46;
    if (i == 1) return (b >= 8'h31) && (b <= 8'(48 + NF));
    if (i == 2) return b == 8'h20;
    return (b >= 8'h30) && (b <= 8'h39) && ((i - 3) < MD);
  endfunction

  // 0 pending, 1 commit, 2 error on this byte, 3 nothing to report
  function automatic int verdict(input logic [7:0] q[$], output int f, output int v);
    int n, p;
    n = q.size();
    p = n - 1;
    f = 0;
    v = 0;
    for (int i = 0; i < p; i++) if (!ok_at(q[i], i)) return 3;
    if (q[p] == 8'h0A) begin
      if (p == 0) return 3;
      if (p < 4) return 2;
      for (int i = 3; i < p; i++) v = v * 10 + (int'(q[i]) - 48);
      f = int'(q[1]) - 48;
      if (v > (2 ** PW) - 1) return 2;
      return 1;
    end
    return ok_at(q[p], p) ? 0 : 2;
  endfunction

  always @(posedge clk) begin
    int r, f, v;
    m_vld = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      for (int k = 0; k < NF; k++) m_pos[k] = '0;
      m_finger = '0;
      m_value  = '0;
      m_cnt    = '0;
      line.delete();
    end else if (dv && rx != 8'h0D) begin
      line.push_back(rx);
      r = verdict(line, f, v);
      if (r == 1) begin
        m_vld        = 1'b1;
        m_pos[f - 1] = 16'(v);
        m_finger     = 4'(f);
        m_value      = 16'(v);
      end else if (r == 2) begin
        m_err = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (rx == 8'h0A) line.delete();
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    logic [NF*PW-1:0] ep;
    n_vld += int'(o_pos_valid);
    n_err += int'(o_frame_error);
    if (chk_en) begin
      for (int k = 0; k < NF; k++) ep[k*PW +: PW] = m_pos[k];
      chk("position", o_position, ep);
      chk("pos_valid", o_pos_valid, m_vld);
      chk("pos_finger", o_pos_finger, m_finger);
      chk("pos_value", o_pos_value, m_value);
      chk("frame_error", o_frame_error, m_err);
      chk("error_count", o_error_count, m_cnt);
      chk("valid_and_error", o_pos_valid & o_frame_error, 1'b0);
    end
  end

  // called aligned to a falling edge; returns on the falling edge after the last byte's sampling edge
  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++) begin
      dv = 1'b1;
      rx = s[i];
      @(negedge clk);
      dv = 1'b0;
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  task automatic snap();
    @(negedge clk);
    #1;
    v0 = n_vld;
    e0 = n_err;
  endtask

  task automatic pulses(input string name, input int ev, input int ee);
    repeat (2) @(negedge clk);
    #1;
    chk({name, "_vld_pulses"}, 80'(n_vld - v0), 80'(ev));
    chk({name, "_err_pulses"}, 80'(n_err - e0), 80'(ee));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    dv  = 1'b0;
    rx  = 8'h00;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_position", o_position, 80'd0);
    chk("reset_count", o_error_count, 80'd0);
    chk("reset_valid", o_pos_valid, 80'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic commit, literal pins
    send_str("F3 1234\n", 0);
    chk("t1_valid", o_pos_valid, 80'd1);
    chk("t1_finger", o_pos_finger, 80'd3);
    chk("t1_value", o_pos_value, 80'd1234);
    chk("t1_position", o_position, 80'd1234 << 32);

    // max value, then overflow
    send_str("F1 65535\n", 0);
    chk("t2_value", o_pos_value, 80'd65535);
    send_str("F1 65536\n", 0);
    chk("t2_ovf_err", o_frame_error, 80'd1);
    chk("t2_field1", o_position[15:0], 80'd65535);
    chk("t2_count", o_error_count, 80'd1);

    // four malformed frames
    do_reset();
    snap();
    send_str("F6 10\nFx\n", 0);
    send_str("F2 12345", 0);
    send_str("6", 0);
    chk("t3_sixth_digit_err", o_frame_error, 80'd1);
    send_str("7\n", 0);
    chk("t3_skip_silent", o_frame_error, 80'd0);
    send_str("F2 \n", 0);
    pulses("t3", 0, 4);
    chk("t3_count", o_error_count, 80'd4);

    // gapped DV with carriage return
    snap();
    send_str("F5 7\015\n", 3);
    pulses("t4", 1, 0);
    chk("t4_finger", o_pos_finger, 80'd5);
    chk("t4_field5", o_position[79:64], 80'd7);

    // reset mid-frame, reset beating DV on the same cycle
    send_str("F4 99", 0);
    rst = 1'b1;
    dv  = 1'b1;
    rx  = 8'h0A;
    @(negedge clk);
    rst = 1'b0;
    dv  = 1'b0;
    snap();
    send_str("F4 42\n", 0);
    pulses("t5", 1, 0);
    chk("t5_field4", o_position[63:48], 80'd42);
    chk("t5_count", o_error_count, 80'd0);

    // back-to-back frames, empty lines, leading zeros
    snap();
    send_str("F1 5\nF2 6\n\n\nF1 00012\nF3 000123\n", 0);
    pulses("t6", 3, 1);
    chk("t6_field1", o_position[15:0], 80'd12);
    chk("t6_field2", o_position[31:16], 80'd6);

    // counter saturation
    @(negedge clk);
    #2;
    force dut.err_cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.err_cnt_q;
    @(negedge clk);
    send_str("x\n", 0);
    chk("t7_count_ffff", o_error_count, 80'hFFFF);
    send_str("G", 0);
    chk("t7_sat_pulse", o_frame_error, 80'd1);
    chk("t7_sat_count", o_error_count, 80'hFFFF);
    send_str("\n", 0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
